// File: rtl/bf_pkg.sv
// Shared constants and helpers for the radix-2 butterfly pipeline (bf_r2_pipe, bf_cmul).
// Complex samples are packed {re, im} with the real part in the upper half.
package bf_pkg;

   localparam int unsigned DW_DEF  = 12;
   localparam int unsigned TW_DEF  = 12;

   localparam int unsigned RE_HALF = 1;
   localparam int unsigned IM_HALF = 0;

   // Half-LSB of the Q1.(tw-1) product scaling, for round-half-up.
   function automatic longint rnd_const(input int unsigned tw);
      return longint'(1) <<< (tw - 2);
   endfunction

   function automatic longint sat_max(input int unsigned dw);
      return (longint'(1) <<< (dw - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int unsigned dw);
      return -(longint'(1) <<< (dw - 1));
   endfunction

endpackage

// File: rtl/bf_cmul.sv
// Registered complex multiplier B*W (or B*conj(W) when inv), rounded back to
// DW+2 bits; forms the S2 stage of bf_r2_pipe.
module bf_cmul
   import bf_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned TW = TW_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic [2*DW-1:0]      b,
   input  logic [2*TW-1:0]      w,
   input  logic                 inv,
   output logic                 out_valid,
   output logic signed [DW+1:0] t_re,
   output logic signed [DW+1:0] t_im
);

   localparam int unsigned PW = DW + TW + 1;
   localparam logic signed [PW-1:0] RND = PW'(rnd_const(TW));

   logic signed [DW-1:0] br, bi;
   logic signed [TW-1:0] wr, wi;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir, p_re, p_im;

   assign br = b[RE_HALF*DW +: DW];
   assign bi = b[IM_HALF*DW +: DW];
   assign wr = w[RE_HALF*TW +: TW];
   assign wi = w[IM_HALF*TW +: TW];

   always_comb begin
      p_rr = PW'(br) * PW'(wr);
      p_ii = PW'(bi) * PW'(wi);
      p_ri = PW'(br) * PW'(wi);
      p_ir = PW'(bi) * PW'(wr);
      if (inv) begin
         p_re = p_rr + p_ii;
         p_im = p_ir - p_ri;
      end else begin
         p_re = p_rr - p_ii;
         p_im = p_ri + p_ir;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         t_re      <= '0;
         t_im      <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         t_re      <= (DW+2)'((p_re + RND) >>> (TW - 1));
         t_im      <= (DW+2)'((p_im + RND) >>> (TW - 1));
      end
   end

endmodule

// File: rtl/bf_r2_pipe.sv
// Pipelined radix-2 DIT butterfly: C1 = A + B*W, C2 = A - B*W, 3-stage, valid/ready.
// Optional macro BF_SAT_EN: clamp out-of-range outputs instead of wrapping.
module bf_r2_pipe
   import bf_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned TW = TW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*DW-1:0] a,
   input  logic [2*DW-1:0] b,
   input  logic [2*TW-1:0] w,
   input  logic            inv,
   input  logic            scale,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*DW-1:0] c1,
   output logic [2*DW-1:0] c2,
   output logic            ovf,
   output logic            ovf_sticky,
   input  logic            clr
);

   localparam int unsigned SW = DW + 3;
   localparam logic signed [SW-1:0] LIM_HI = SW'(sat_max(DW));
   localparam logic signed [SW-1:0] LIM_LO = SW'(sat_min(DW));

   logic            adv;
   logic            s1_v, s1_inv, s1_scale, s2_v, s2_scale;
   logic [2*DW-1:0] s1_a, s1_b, s2_a;
   logic [2*TW-1:0] s1_w;
   logic signed [DW+1:0] t_re, t_im;

   // Single global stall: every stage moves together, bubbles are kept.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v     <= 1'b0;
         s1_inv   <= 1'b0;
         s1_scale <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_w     <= '0;
         s2_a     <= '0;
         s2_scale <= 1'b0;
      end else if (adv) begin
         s1_v     <= in_valid;
         s1_inv   <= inv;
         s1_scale <= scale;
         s1_a     <= a;
         s1_b     <= b;
         s1_w     <= w;
         s2_a     <= s1_a;
         s2_scale <= s1_scale;
      end
   end

   bf_cmul #(.DW(DW), .TW(TW)) u_cmul (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv),
      .in_valid  (s1_v),
      .b         (s1_b),
      .w         (s1_w),
      .inv       (s1_inv),
      .out_valid (s2_v),
      .t_re      (t_re),
      .t_im      (t_im)
   );

   logic signed [DW-1:0] a_re, a_im;
   logic signed [SW-1:0] sum [4];
   logic [DW-1:0]        lim [4];
   logic                 oor;

   assign a_re = s2_a[RE_HALF*DW +: DW];
   assign a_im = s2_a[IM_HALF*DW +: DW];

   // Order: c1_re, c1_im, c2_re, c2_im.
   always_comb begin
      sum[0] = SW'(a_re) + SW'(t_re);
      sum[1] = SW'(a_im) + SW'(t_im);
      sum[2] = SW'(a_re) - SW'(t_re);
      sum[3] = SW'(a_im) - SW'(t_im);
      oor    = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (s2_scale)
            sum[i] = (sum[i] + SW'(1)) >>> 1;
         oor = oor || (sum[i] > LIM_HI) || (sum[i] < LIM_LO);
`ifdef BF_SAT_EN
         if (sum[i] > LIM_HI)
            lim[i] = LIM_HI[DW-1:0];
         else if (sum[i] < LIM_LO)
            lim[i] = LIM_LO[DW-1:0];
         else
            lim[i] = sum[i][DW-1:0];
`else
         lim[i] = sum[i][DW-1:0];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         c1        <= '0;
         c2        <= '0;
         ovf       <= 1'b0;
      end else if (adv) begin
         out_valid <= s2_v;
         c1        <= {lim[0], lim[1]};
         c2        <= {lim[2], lim[3]};
         ovf       <= s2_v && oor;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_sticky <= 1'b0;
      else if (clr)
         ovf_sticky <= 1'b0;
      else if (out_valid && out_ready && ovf)
         ovf_sticky <= 1'b1;
   end

endmodule

// File: tb/tb_bf_r2_pipe.sv
// Directed self-checking bench for bf_r2_pipe (DW = TW = 12).
module tb_bf_r2_pipe;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, inv, scale;
   logic        out_valid, out_ready, ovf, ovf_sticky, clr;
   logic [23:0] a, b, w, c1, c2;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   bf_r2_pipe #(.DW(12), .TW(12)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .w          (w),
      .inv        (inv),
      .scale      (scale),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .c1         (c1),
      .c2         (c2),
      .ovf        (ovf),
      .ovf_sticky (ovf_sticky),
      .clr        (clr)
   );

   // Drive one beat with out_ready high; return once its result is presented.
   task automatic run_beat(input logic [23:0] ta, tb_v, tw, input logic ti, ts,
                           output logic [23:0] r1, r2, output logic rov, output int lat);
      @(negedge clk);
      a = ta; b = tb_v; w = tw; inv = ti; scale = ts;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      r1 = c1; r2 = c2; rov = ovf;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
      a = '0; b = '0; w = '0; inv = 1'b0; scale = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_tests++; if (c1 !== 24'h0 || c2 !== 24'h0) begin n_fail++; $display("FAIL reset_c got %h/%h want 0/0", c1, c2); end
      n_tests++; if (ovf !== 1'b0 || ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b/%b want 0/0", ovf, ovf_sticky); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      @(negedge clk); rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_basic();
      logic [23:0] r1, r2; logic rov; int lat;
      run_beat(24'h100000, 24'h100000, 24'h7FF000, 1'b0, 1'b0, r1, r2, rov, lat);
      n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency got %0d want 3", lat); end
      n_tests++; if (r1 !== 24'h200000) begin n_fail++; $display("FAIL basic_c1 got %h want 200000", r1); end
      n_tests++; if (r2 !== 24'h000000) begin n_fail++; $display("FAIL basic_c2 got %h want 000000", r2); end
      n_tests++; if (rov !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %b want 0", rov); end
      run_beat(24'h100000, 24'h100000, 24'h7FF000, 1'b0, 1'b1, r1, r2, rov, lat);
      n_tests++; if (r1 !== 24'h100000) begin n_fail++; $display("FAIL scale_c1 got %h want 100000", r1); end
      n_tests++; if (r2 !== 24'h000000) begin n_fail++; $display("FAIL scale_c2 got %h want 000000", r2); end
      idle(2);
   endtask

   task automatic test_inv();
      logic [23:0] r1, r2; logic rov; int lat;
      run_beat(24'h000000, 24'h100000, 24'h000801, 1'b0, 1'b0, r1, r2, rov, lat);
      n_tests++; if (r1 !== 24'h000F00) begin n_fail++; $display("FAIL fwd_c1 got %h want 000f00", r1); end
      n_tests++; if (r2 !== 24'h000100) begin n_fail++; $display("FAIL fwd_c2 got %h want 000100", r2); end
      run_beat(24'h000000, 24'h100000, 24'h000801, 1'b1, 1'b0, r1, r2, rov, lat);
      n_tests++; if (r1 !== 24'h000100) begin n_fail++; $display("FAIL inv_c1 got %h want 000100", r1); end
      n_tests++; if (r2 !== 24'h000F00) begin n_fail++; $display("FAIL inv_c2 got %h want 000f00", r2); end
      idle(2);
   endtask

   task automatic test_ovf();
      logic [23:0] r1, r2, e1; logic rov; int lat;
`ifdef BF_SAT_EN
      e1 = 24'h7FF000;
`else
      e1 = 24'hFFD000;
`endif
      run_beat(24'h7FF000, 24'h7FF000, 24'h7FF000, 1'b0, 1'b0, r1, r2, rov, lat);
      n_tests++; if (r1 !== e1) begin n_fail++; $display("FAIL ovf_c1 got %h want %h", r1, e1); end
      n_tests++; if (r2 !== 24'h001000) begin n_fail++; $display("FAIL ovf_c2 got %h want 001000", r2); end
      n_tests++; if (rov !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", rov); end
      @(posedge clk); #1;
      n_tests++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky_set got %b want 1", ovf_sticky); end
      @(negedge clk); clr = 1'b1;
      @(posedge clk); #1; clr = 1'b0;
      n_tests++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky_clr got %b want 0", ovf_sticky); end
      // clr on the same edge the overflowing result is consumed must win
      run_beat(24'h7FF000, 24'h7FF000, 24'h7FF000, 1'b0, 1'b0, r1, r2, rov, lat);
      clr = 1'b1;
      @(posedge clk); #1; clr = 1'b0;
      n_tests++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_priority got %b want 0", ovf_sticky); end
      idle(2);
   endtask

   task automatic test_back_to_back();
      int sent = 0, rcv = 0, cyc = 0, extra = 0;
      logic stall_seen = 1'b0;
      logic [23:0] h1, h2, e1, e2;
      logic [11:0] ar;
      while (rcv < 8 && cyc < 60) begin
         @(negedge clk);
         out_ready = !(cyc >= 4 && cyc < 8);
         in_valid  = (sent < 8);
         a = {12'(16*sent + 1), 12'h020};
         b = 24'h100000; w = 24'h000801; inv = sent[0]; scale = 1'b0;
         #1;
         if (out_valid && !out_ready) begin
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
            if (stall_seen) begin
               n_tests++;
               if (c1 !== h1 || c2 !== h2) begin n_fail++; $display("FAIL stall_hold got %h/%h want %h/%h", c1, c2, h1, h2); end
            end
            stall_seen = 1'b1; h1 = c1; h2 = c2;
         end
         if (out_valid && out_ready) begin
            ar = 12'(16*rcv + 1);
            e1 = rcv[0] ? {ar, 12'h120} : {ar, 12'hF20};
            e2 = rcv[0] ? {ar, 12'hF20} : {ar, 12'h120};
            n_tests++;
            if (c1 !== e1 || c2 !== e2) begin n_fail++; $display("FAIL stream_%0d got %h/%h want %h/%h", rcv, c1, c2, e1, e2); end
            rcv++;
         end
         if (in_valid && in_ready) sent++;
         cyc++;
      end
      n_tests++; if (rcv !== 8 || !stall_seen) begin n_fail++; $display("FAIL stream_count got %0d (stall %b) want 8 (stall 1)", rcv, stall_seen); end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid) extra++;
      end
      n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL stream_extra got %0d want 0", extra); end
   endtask

   task automatic test_async_reset();
      logic [23:0] r1, r2; logic rov; int lat; int ghost = 0;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1;
      a = 24'h100000; b = 24'h100000; w = 24'h7FF000; inv = 1'b0; scale = 1'b0;
      @(negedge clk);
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #2;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got %b want 1", out_valid); end
      rst_n = 1'b0;
      #1;
      n_tests++; if (out_valid !== 1'b0 || c1 !== 24'h0) begin n_fail++; $display("FAIL async_reset got %b/%h want 0/000000", out_valid, c1); end
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (out_valid) ghost++;
      end
      n_tests++; if (ghost !== 0) begin n_fail++; $display("FAIL reset_discard got %0d want 0", ghost); end
      run_beat(24'h100000, 24'h100000, 24'h7FF000, 1'b0, 1'b0, r1, r2, rov, lat);
      n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL post_reset_latency got %0d want 3", lat); end
      n_tests++; if (r1 !== 24'h200000) begin n_fail++; $display("FAIL post_reset_c1 got %h want 200000", r1); end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_inv();
      test_ovf();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
